// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode and execute
// steps, stalling on a single-port memory via mem_ready.
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'd0,
    parameter logic [5:0] OP_LW    = 6'd35,
    parameter logic [5:0] OP_SW    = 6'd43,
    parameter logic [5:0] OP_BEQ   = 6'd4,
    parameter logic [5:0] OP_ADDI  = 6'd8,
    parameter logic [5:0] OP_ANDI  = 6'd12,
    parameter logic [5:0] OP_J     = 6'd2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] Op,
    input  logic       jr,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic       done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StIExec   = 4'd9,
        StIWb     = 4'd10,
        StJump    = 4'd11,
        StTrap    = 4'd12
    } state_e;

    state_e state_q, state_d;
    logic   imm_and_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StFetch;
            imm_and_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                imm_and_q <= (Op == OP_ANDI);
            end
        end
    end

    assign state = state_q;

    always_comb begin
        state_d     = StFetch;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        done        = 1'b0;
        illegal     = 1'b0;

        case (state_q)
            StFetch: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                state_d = mem_ready ? StDecode : StFetch;
            end
            StDecode: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW:     state_d = StMemAdr;
                    OP_RTYPE:         state_d = StExecute;
                    OP_BEQ:           state_d = StBranch;
                    OP_ADDI, OP_ANDI: state_d = StIExec;
                    OP_J:             state_d = StJump;
                    default:          state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Op == OP_LW) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = mem_ready ? StMemWb : StMemRd;
            end
            StMemWb: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                done     = 1'b1;
            end
            StMemWr: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                done     = mem_ready;
                state_d  = mem_ready ? StFetch : StMemWr;
            end
            StExecute: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                // jr retires here; ordinary R-type continues to writeback
                if (jr) begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b11;
                    done     = 1'b1;
                end else begin
                    state_d = StAluWb;
                end
            end
            StAluWb: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                done     = 1'b1;
            end
            StBranch: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                done        = 1'b1;
            end
            StIExec: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = imm_and_q ? 2'b11 : 2'b00;
                state_d = StIWb;
            end
            StIWb: begin
                RegWrite = 1'b1;
                done     = 1'b1;
            end
            StJump: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                done     = 1'b1;
            end
            StTrap: begin
                illegal = 1'b1;
                done    = 1'b1;
            end
            default: state_d = StFetch;
        endcase

        // Reset masks every strobe in the same cycle so a mid-instruction reset cannot write
        if (!reset_n) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            MemtoReg    = 1'b0;
            IRWrite     = 1'b0;
            ALUSrcA     = 1'b0;
            RegWrite    = 1'b0;
            RegDst      = 1'b0;
            ALUOp       = 2'b00;
            ALUSrcB     = 2'b00;
            PCSource    = 2'b00;
            done        = 1'b0;
            illegal     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control: per-cycle vectors with expected outputs go
// through a scoreboard queue and are compared mid-cycle.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] Op;
    logic       jr;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst, done, illegal;
    logic [1:0] ALUOp, ALUSrcB, PCSource;
    logic [3:0] state;

    multicycle_control dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Op         (Op),
        .jr         (jr),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .IRWrite    (IRWrite),
        .ALUSrcA    (ALUSrcA),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .ALUOp      (ALUOp),
        .ALUSrcB    (ALUSrcB),
        .PCSource   (PCSource),
        .done       (done),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Flag order: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite ALUSrcA RegWrite RegDst
    localparam logic [9:0] F_NONE    = 10'b0000000000;
    localparam logic [9:0] F_FETCH   = 10'b1001001000;
    localparam logic [9:0] F_FSTALL  = 10'b0001000000;
    localparam logic [9:0] F_SRCA    = 10'b0000000100;
    localparam logic [9:0] F_MEMRD   = 10'b0011000000;
    localparam logic [9:0] F_MEMWB   = 10'b0000010010;
    localparam logic [9:0] F_MEMWR   = 10'b0010100000;
    localparam logic [9:0] F_JR      = 10'b1000000100;
    localparam logic [9:0] F_ALUWB   = 10'b0000000011;
    localparam logic [9:0] F_BRANCH  = 10'b0100000100;
    localparam logic [9:0] F_IWB     = 10'b0000000010;
    localparam logic [9:0] F_JUMP    = 10'b1000000000;

    typedef struct packed {
        logic        rst_n;
        logic [5:0]  op;
        logic        jr;
        logic        mr;
        logic [21:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [21:0] exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          n_done = 0;

    function automatic logic [21:0] e(input logic [3:0] st, input logic [9:0] fl,
                                      input logic [1:0] aop, input logic [1:0] srcb,
                                      input logic [1:0] pcs, input logic dn, input logic ill);
        return {fl, aop, srcb, pcs, dn, ill, st};
    endfunction

    task automatic add(input logic r, input logic [5:0] o, input logic j, input logic m,
                       input logic [21:0] x);
        vec_t v;
        v.rst_n = r;
        v.op    = o;
        v.jr    = j;
        v.mr    = m;
        v.exp   = x;
        vecs.push_back(v);
    endtask

    function automatic logic [21:0] actual();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
                RegWrite, RegDst, ALUOp, ALUSrcB, PCSource, done, illegal, state};
    endfunction

    initial begin
        logic [21:0] want;
        logic [21:0] got;

        // Reset and a jump
        add(0, 6'd2, 0, 1, e(4'd0, F_NONE, 2'b00, 2'b00, 2'b00, 0, 0));
        add(1, 6'd2, 0, 1, e(4'd0, F_FETCH, 2'b00, 2'b01, 2'b00, 0, 0));
        add(1, 6'd2, 0, 1, e(4'd1, F_NONE, 2'b00, 2'b11, 2'b00, 0, 0));
        add(1, 6'd2, 0, 1, e(4'd11, F_JUMP, 2'b00, 2'b00, 2'b10, 1, 0));
        // lw with two stall cycles in FETCH and in MEMRD
        add(1, 6'd35, 0, 0, e(4'd0, F_FSTALL, 2'b00, 2'b01, 2'b00, 0, 0));
        add(1, 6'd35, 0, 0, e(4'd0, F_FSTALL, 2'b00, 2'b01, 2'b00, 0, 0));
        add(1, 6'd35, 0, 1, e(4'd0, F_FETCH, 2'b00, 2'b01, 2'b00, 0, 0));
        add(1, 6'd35, 0, 1, e(4'd1, F_NONE, 2'b00, 2'b11, 2'b00, 0, 0));
        add(1, 6'd35, 0, 1, e(4'd2, F_SRCA, 2'b00, 2'b10, 2'b00, 0, 0));
        add(1, 6'd35, 0, 0, e(4'd3, F_MEMRD, 2'b00, 2'b00, 2'b00, 0, 0));
        add(1, 6'd35, 0, 0, e(4'd3, F_MEMRD, 2'b00, 2'b00, 2'b00, 0, 0));
        add(1, 6'd35, 0, 1, e(4'd3, F_MEMRD, 2'b00, 2'b00, 2'b00, 0, 0));
        add(1, 6'd35, 0, 1, e(4'd4, F_MEMWB, 2'b00, 2'b00, 2'b00, 1, 0));
        // sw
        add(1, 6'd43, 0, 1, e(4'd0, F_FETCH, 2'b00, 2'b01, 2'b00, 0, 0));
        add(1, 6'd43, 0, 1, e(4'd1, F_NONE, 2'b00, 2'b11, 2'b00, 0, 0));
        add(1, 6'd43, 0, 1, e(4'd2, F_SRCA, 2'b00, 2'b10, 2'b00, 0, 0));
        add(1, 6'd43, 0, 1, e(4'd5, F_MEMWR, 2'b00, 2'b00, 2'b00, 1, 0));
        // jr
        add(1, 6'd0, 1, 1, e(4'd0, F_FETCH, 2'b00, 2'b01, 2'b00, 0, 0));
        add(1, 6'd0, 1, 1, e(4'd1, F_NONE, 2'b00, 2'b11, 2'b00, 0, 0));
        add(1, 6'd0, 1, 1, e(4'd6, F_JR, 2'b10, 2'b00, 2'b11, 1, 0));
        // plain R-type
        add(1, 6'd0, 0, 1, e(4'd0, F_FETCH, 2'b00, 2'b01, 2'b00, 0, 0));
        add(1, 6'd0, 0, 1, e(4'd1, F_NONE, 2'b00, 2'b11, 2'b00, 0, 0));
        add(1, 6'd0, 0, 1, e(4'd6, F_SRCA, 2'b10, 2'b00, 2'b00, 0, 0));
        add(1, 6'd0, 0, 1, e(4'd7, F_ALUWB, 2'b00, 2'b00, 2'b00, 1, 0));
        // andi then addi: imm_and must clear again
        add(1, 6'd12, 0, 1, e(4'd0, F_FETCH, 2'b00, 2'b01, 2'b00, 0, 0));
        add(1, 6'd12, 0, 1, e(4'd1, F_NONE, 2'b00, 2'b11, 2'b00, 0, 0));
        add(1, 6'd12, 0, 1, e(4'd9, F_SRCA, 2'b11, 2'b10, 2'b00, 0, 0));
        add(1, 6'd12, 0, 1, e(4'd10, F_IWB, 2'b00, 2'b00, 2'b00, 1, 0));
        add(1, 6'd8, 0, 1, e(4'd0, F_FETCH, 2'b00, 2'b01, 2'b00, 0, 0));
        add(1, 6'd8, 1, 0, e(4'd1, F_NONE, 2'b00, 2'b11, 2'b00, 0, 0));
        add(1, 6'd8, 0, 1, e(4'd9, F_SRCA, 2'b00, 2'b10, 2'b00, 0, 0));
        add(1, 6'd8, 0, 1, e(4'd10, F_IWB, 2'b00, 2'b00, 2'b00, 1, 0));
        // beq with mem_ready low outside memory states (must be ignored)
        add(1, 6'd4, 0, 1, e(4'd0, F_FETCH, 2'b00, 2'b01, 2'b00, 0, 0));
        add(1, 6'd4, 0, 0, e(4'd1, F_NONE, 2'b00, 2'b11, 2'b00, 0, 0));
        add(1, 6'd4, 0, 0, e(4'd8, F_BRANCH, 2'b01, 2'b00, 2'b01, 1, 0));
        // illegal opcode
        add(1, 6'd63, 0, 1, e(4'd0, F_FETCH, 2'b00, 2'b01, 2'b00, 0, 0));
        add(1, 6'd63, 0, 1, e(4'd1, F_NONE, 2'b00, 2'b11, 2'b00, 0, 0));
        add(1, 6'd63, 0, 1, e(4'd12, F_NONE, 2'b00, 2'b00, 2'b00, 1, 1));
        // sw aborted by reset while stalled in MEMWR
        add(1, 6'd43, 0, 1, e(4'd0, F_FETCH, 2'b00, 2'b01, 2'b00, 0, 0));
        add(1, 6'd43, 0, 1, e(4'd1, F_NONE, 2'b00, 2'b11, 2'b00, 0, 0));
        add(1, 6'd43, 0, 1, e(4'd2, F_SRCA, 2'b00, 2'b10, 2'b00, 0, 0));
        add(1, 6'd43, 0, 0, e(4'd5, F_MEMWR, 2'b00, 2'b00, 2'b00, 0, 0));
        add(0, 6'd43, 0, 0, e(4'd5, F_NONE, 2'b00, 2'b00, 2'b00, 0, 0));
        add(1, 6'd2, 0, 1, e(4'd0, F_FETCH, 2'b00, 2'b01, 2'b00, 0, 0));
        add(1, 6'd2, 0, 1, e(4'd1, F_NONE, 2'b00, 2'b11, 2'b00, 0, 0));
        add(1, 6'd2, 0, 1, e(4'd11, F_JUMP, 2'b00, 2'b00, 2'b10, 1, 0));

        reset_n   = 1'b0;
        Op        = 6'd0;
        jr        = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset_n   = vecs[i].rst_n;
            Op        = vecs[i].op;
            jr        = vecs[i].jr;
            mem_ready = vecs[i].mr;
            exp_q.push_back(vecs[i].exp);
            @(negedge clk);
            want = exp_q.pop_front();
            got  = actual();
            if (done === 1'b1) n_done++;
            n_vec++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL vec%0d: got flags=%b aluop=%b srcb=%b pcsrc=%b done=%b ill=%b st=%0d, want flags=%b aluop=%b srcb=%b pcsrc=%b done=%b ill=%b st=%0d",
                         i, got[21:12], got[11:10], got[9:8], got[7:6], got[5], got[4],
                         got[3:0], want[21:12], want[11:10], want[9:8], want[7:6], want[5],
                         want[4], want[3:0]);
            end
            @(posedge clk);
            #1;
        end

        // Ten completed instructions; the reset-aborted sw must not pulse done
        n_vec++;
        if (n_done != 10) begin
            n_bad++;
            $display("FAIL done_count: got %0d, want 10", n_done);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
